// File: rtl/usb_sie_pkg.sv
// Shared types and constants for the device-side USB SIE transmit path.
// bus8_t mirrors the 8-bit UTM data bus type so both sides of the UTM agree on width.
package usb_sie_pkg;

    typedef logic [7:0] bus8_t;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SOF   = 4'b0101,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_DATA2 = 4'b0111,
        PID_MDATA = 4'b1111,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110,
        PID_NYET  = 4'b0110
    } pid_t;

    // Packet class is carried in the two low PID bits.
    localparam logic [1:0] PID_CLASS_DATA = 2'b11;
    localparam logic [1:0] PID_CLASS_HS   = 2'b10;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_DATA,
        ST_CRC_LO,
        ST_CRC_HI
    } tx_state_t;

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

    function automatic bus8_t pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Combinational byte-wise USB CRC16 update, data taken LSB first.
// Shared with the receive-side SIE, which runs the same update for checking.
module usb_crc16
    import usb_sie_pkg::*;
(
    input  logic [15:0] crc_in,
    input  bus8_t       data,
    output logic [15:0] crc_out
);

    // Bit-reflected register form: LSB-first data shifts right through the reversed polynomial.
    localparam logic [15:0] POLY_REFL = rev16(CRC16_POLY);

    function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input bus8_t d);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) begin
                c = (c >> 1) ^ POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    assign crc_out = crc16_byte(crc_in, data);

endmodule

// File: rtl/usb_sie_tx.sv
// Device-side SIE packet transmitter: PID byte, optional payload and CRC16 onto the UTM 8-bit tx port.
// The state name always reflects which byte is currently presented on utm_data_out.
module usb_sie_tx
    import usb_sie_pkg::*;
#(
    parameter int MAX_PKT = 1023,
    parameter int LEN_W   = $clog2(MAX_PKT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_start,
    input  logic [3:0]       tx_pid,
    input  logic [LEN_W-1:0] tx_len,
    input  bus8_t            pl_data,
    input  logic             pl_valid,
    output logic             pl_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output bus8_t            utm_data_out,
    output logic             utm_tx_valid,
    input  logic             utm_tx_ready
);

    tx_state_t        state, state_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic [15:0]      crc, crc_nxt, crc_upd;
    logic             hs_pkt, hs_nxt;
    bus8_t            data_nxt;
    logic             valid_nxt, busy_nxt, done_nxt, err_nxt;
    logic             req_data, req_hs, len_ok, req_ok;
    logic             bytes_left, pay_phase;

    assign req_data   = (tx_pid[1:0] == PID_CLASS_DATA);
    assign req_hs     = (tx_pid[1:0] == PID_CLASS_HS);
    assign len_ok     = (32'(tx_len) <= 32'(MAX_PKT));
    assign req_ok     = req_hs || (req_data && len_ok);
    assign bytes_left = |cnt;
    assign pay_phase  = ((state == ST_PID) && !hs_pkt) || (state == ST_DATA);

    // A payload byte is taken exactly when the byte ahead of it leaves the bus.
    assign pl_ready = pay_phase && bytes_left && utm_tx_valid && utm_tx_ready && pl_valid;

    usb_crc16 u_crc (
        .crc_in  (crc),
        .data    (pl_data),
        .crc_out (crc_upd)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        crc_nxt   = crc;
        hs_nxt    = hs_pkt;
        data_nxt  = utm_data_out;
        valid_nxt = utm_tx_valid;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (tx_start) begin
                    if (req_ok) begin
                        state_nxt = ST_PID;
                        hs_nxt    = req_hs;
                        cnt_nxt   = req_hs ? '0 : tx_len;
                        crc_nxt   = CRC16_INIT;
                        data_nxt  = pid_byte(tx_pid);
                        valid_nxt = 1'b1;
                        busy_nxt  = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end

            ST_PID, ST_DATA: begin
                if (utm_tx_ready) begin
                    if (hs_pkt) begin
                        state_nxt = ST_IDLE;
                        data_nxt  = '0;
                        valid_nxt = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else if (bytes_left) begin
                        if (pl_valid) begin
                            state_nxt = ST_DATA;
                            data_nxt  = pl_data;
                            crc_nxt   = crc_upd;
                            cnt_nxt   = cnt - LEN_W'(1);
                        end else begin
                            // Underrun: abandon the packet; the host sees a bad CRC.
                            state_nxt = ST_IDLE;
                            data_nxt  = '0;
                            valid_nxt = 1'b0;
                            busy_nxt  = 1'b0;
                            err_nxt   = 1'b1;
                        end
                    end else begin
                        state_nxt = ST_CRC_LO;
                        data_nxt  = ~crc[7:0];
                    end
                end
            end

            ST_CRC_LO: begin
                if (utm_tx_ready) begin
                    state_nxt = ST_CRC_HI;
                    data_nxt  = ~crc[15:8];
                end
            end

            ST_CRC_HI: begin
                if (utm_tx_ready) begin
                    state_nxt = ST_IDLE;
                    data_nxt  = '0;
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                data_nxt  = '0;
                valid_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            utm_data_out <= '0;
            utm_tx_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            utm_data_out <= data_nxt;
            utm_tx_valid <= valid_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            err          <= err_nxt;
        end
    end

    // Working registers are always reloaded at tx_start, so they carry no reset.
    always_ff @(posedge clk) begin
        cnt    <= cnt_nxt;
        crc    <= crc_nxt;
        hs_pkt <= hs_nxt;
    end

endmodule

// File: tb/tb_usb_sie_tx.sv
// Directed bench for usb_sie_tx: handshake, data, CRC, underrun, rejection, reset and back-to-back cases.
module tb_usb_sie_tx;

    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_start;
    logic [3:0]    tx_pid;
    logic [LW-1:0] tx_len;
    logic [7:0]    pl_data;
    logic          pl_valid;
    logic          pl_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [7:0]    utm_data_out;
    logic          utm_tx_valid;
    logic          utm_tx_ready;

    int errors = 0;
    int checks = 0;

    logic [7:0] pay  [0:15];
    logic [7:0] cap  [0:15];
    logic [7:0] expb [0:15];

    int n_b, vcyc, done_n, err_n, plr, unstable;
    bit tmo;

    always #5 clk = ~clk;

    usb_sie_tx #(.MAX_PKT(1023), .LEN_W(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_start     (tx_start),
        .tx_pid       (tx_pid),
        .tx_len       (tx_len),
        .pl_data      (pl_data),
        .pl_valid     (pl_valid),
        .pl_ready     (pl_ready),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .utm_data_out (utm_data_out),
        .utm_tx_valid (utm_tx_valid),
        .utm_tx_ready (utm_tx_ready)
    );

    // Reference CRC in the non-reflected shift-left form, mapped back to the transmitted register order.
    function automatic logic [15:0] crc_model(input int cnt);
        logic [15:0] c;
        logic [15:0] r;
        logic        fb;
        c = 16'hFFFF;
        for (int b = 0; b < cnt; b++) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[15] ^ pay[b][i];
                c  = c << 1;
                if (fb) c = c ^ 16'h8005;
            end
        end
        for (int i = 0; i < 16; i++) r[i] = c[15-i];
        return r;
    endfunction

    // Drives one request and records every consumed byte until utm_tx_valid falls.
    task automatic send(input logic [3:0] pid, input int len, input bit toggle, input int under_at,
                        input bit poke, output int n, output int vc, output int dn, output int en,
                        output int pr, output int unst, output bit to);
        int         pidx;
        bit         seen, hold;
        logic [7:0] held;
        n = 0; vc = 0; dn = 0; en = 0; pr = 0; unst = 0; to = 0;
        pidx = 0; seen = 0; hold = 0; held = '0;
        for (int i = 0; i < 16; i++) cap[i] = '0;
        @(posedge clk); #1;
        tx_start = 1'b1; tx_pid = pid; tx_len = LW'(len);
        @(posedge clk); #1;
        for (int k = 0; k < 300; k++) begin
            utm_tx_ready = toggle ? (k % 2 == 0) : 1'b1;
            pl_data  = pay[pidx[3:0]];
            pl_valid = (under_at < 0) || (pidx < under_at);
            if (poke && k == 2) begin
                tx_start = 1'b1; tx_pid = 4'h2; tx_len = '0;
            end else begin
                tx_start = 1'b0;
            end
            #1;
            if (done) dn++;
            if (err) en++;
            if (pl_ready) begin pr++; pidx++; end
            if (utm_tx_valid) begin
                seen = 1; vc++;
                if (hold && utm_data_out !== held) unst++;
                if (utm_tx_ready) begin
                    if (n < 16) cap[n] = utm_data_out;
                    n++; hold = 0;
                end else begin
                    hold = 1; held = utm_data_out;
                end
            end else if (seen || k >= 4) begin
                break;
            end
            if (k == 299) to = 1;
            @(posedge clk); #1;
        end
        tx_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; tx_start = 0; tx_pid = '0; tx_len = '0; pl_data = '0; pl_valid = 0; utm_tx_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (utm_tx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", utm_tx_valid); end
        checks++; if (utm_data_out !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", utm_data_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
        checks++; if (pl_ready !== 1'b0) begin errors++; $display("FAIL rst_pl_ready got %b want 0", pl_ready); end
        #2 rst = 1'b1;
    endtask

    task automatic test_ack();
        send(4'h2, 0, 0, -1, 0, n_b, vcyc, done_n, err_n, plr, unstable, tmo);
        checks++; if (n_b !== 1) begin errors++; $display("FAIL ack_count got %0d want 1", n_b); end
        checks++; if (cap[0] !== 8'hD2) begin errors++; $display("FAIL ack_byte got %h want d2", cap[0]); end
        checks++; if (vcyc !== 1) begin errors++; $display("FAIL ack_valid_cycles got %0d want 1", vcyc); end
        checks++; if (done !== 1'b1 || done_n !== 1) begin errors++; $display("FAIL ack_done got %b/%0d want 1/1", done, done_n); end
        checks++; if (plr !== 0) begin errors++; $display("FAIL ack_pl_ready got %0d want 0", plr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ack_busy got %b want 0", busy); end
    endtask

    task automatic test_data0_zlp();
        send(4'h3, 0, 0, -1, 0, n_b, vcyc, done_n, err_n, plr, unstable, tmo);
        expb[0] = 8'hC3; expb[1] = 8'h00; expb[2] = 8'h00;
        checks++; if (n_b !== 3 || vcyc !== 3) begin errors++; $display("FAIL zlp_count got %0d/%0d want 3/3", n_b, vcyc); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (cap[i] !== expb[i]) begin errors++; $display("FAIL zlp_byte%0d got %h want %h", i, cap[i], expb[i]); end
        end
        checks++; if (done_n !== 1 || err_n !== 0) begin errors++; $display("FAIL zlp_done got %0d/%0d want 1/0", done_n, err_n); end
    endtask

    task automatic test_data1_toggle();
        logic [15:0] r;
        int          late;
        for (int i = 0; i < 4; i++) pay[i] = 8'(i);
        r = crc_model(4);
        expb[0] = 8'h4B; expb[1] = 8'h00; expb[2] = 8'h01; expb[3] = 8'h02; expb[4] = 8'h03;
        expb[5] = ~r[7:0]; expb[6] = ~r[15:8];
        send(4'hB, 4, 1, -1, 1, n_b, vcyc, done_n, err_n, plr, unstable, tmo);
        checks++; if (n_b !== 7) begin errors++; $display("FAIL d1_count got %0d want 7", n_b); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (cap[i] !== expb[i]) begin errors++; $display("FAIL d1_byte%0d got %h want %h", i, cap[i], expb[i]); end
        end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL d1_stable got %0d changes want 0", unstable); end
        checks++; if (plr !== 4) begin errors++; $display("FAIL d1_pl_ready got %0d want 4", plr); end
        checks++; if (done_n !== 1 || err_n !== 0 || tmo !== 0) begin
            errors++; $display("FAIL d1_end got done=%0d err=%0d tmo=%0d want 1/0/0", done_n, err_n, tmo);
        end
        late = 0;
        repeat (4) begin @(posedge clk); #2; if (utm_tx_valid) late++; end
        checks++; if (late !== 0) begin errors++; $display("FAIL busy_start_ignored got %0d valid cycles want 0", late); end
    endtask

    task automatic test_crc_known();
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        send(4'h3, 9, 0, -1, 0, n_b, vcyc, done_n, err_n, plr, unstable, tmo);
        checks++; if (n_b !== 12) begin errors++; $display("FAIL crc9_count got %0d want 12", n_b); end
        checks++; if (cap[10] !== 8'hC8 || cap[11] !== 8'hB4) begin
            errors++; $display("FAIL crc9_bytes got %h %h want c8 b4", cap[10], cap[11]);
        end
    endtask

    task automatic test_underrun();
        for (int i = 0; i < 8; i++) pay[i] = 8'h10 + 8'(i);
        send(4'h3, 8, 0, 3, 0, n_b, vcyc, done_n, err_n, plr, unstable, tmo);
        checks++; if (err !== 1'b1 || err_n !== 1) begin errors++; $display("FAIL ur_err got %b/%0d want 1/1", err, err_n); end
        checks++; if (done_n !== 0) begin errors++; $display("FAIL ur_done got %0d want 0", done_n); end
        checks++; if (busy !== 1'b0 || utm_tx_valid !== 1'b0) begin errors++; $display("FAIL ur_idle got busy=%b valid=%b want 0/0", busy, utm_tx_valid); end
        checks++; if (n_b !== 4 || cap[3] !== 8'h12) begin errors++; $display("FAIL ur_bytes got %0d last %h want 4 last 12", n_b, cap[3]); end
    endtask

    task automatic test_reject();
        send(4'h1, 0, 0, -1, 0, n_b, vcyc, done_n, err_n, plr, unstable, tmo);
        checks++; if (err_n !== 1 || vcyc !== 0) begin errors++; $display("FAIL rej_out got err=%0d valid=%0d want 1/0", err_n, vcyc); end
        send(4'h3, 1024, 0, -1, 0, n_b, vcyc, done_n, err_n, plr, unstable, tmo);
        checks++; if (err_n !== 1 || vcyc !== 0) begin errors++; $display("FAIL rej_len got err=%0d valid=%0d want 1/0", err_n, vcyc); end
        checks++; if (busy !== 1'b0 || done_n !== 0) begin errors++; $display("FAIL rej_state got busy=%b done=%0d want 0/0", busy, done_n); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] r;
        @(posedge clk); #1;
        tx_start = 1; tx_pid = 4'h3; tx_len = LW'(8); pl_data = 8'h11; pl_valid = 1; utm_tx_ready = 1;
        @(posedge clk); #1;
        tx_start = 0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++; if (utm_tx_valid !== 1'b0 || utm_data_out !== 8'h00) begin
            errors++; $display("FAIL rstmid_bus got valid=%b data=%h want 0/00", utm_tx_valid, utm_data_out);
        end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || pl_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_ctl got busy=%b done=%b err=%b rdy=%b want 0000", busy, done, err, pl_ready);
        end
        @(posedge clk); #3 rst = 1'b1;
        pay[0] = 8'hA5; pay[1] = 8'h3C;
        r = crc_model(2);
        expb[0] = 8'hC3; expb[1] = 8'hA5; expb[2] = 8'h3C; expb[3] = ~r[7:0]; expb[4] = ~r[15:8];
        send(4'h3, 2, 0, -1, 0, n_b, vcyc, done_n, err_n, plr, unstable, tmo);
        checks++; if (n_b !== 5 || done_n !== 1 || err_n !== 0) begin
            errors++; $display("FAIL rstmid_pkt got n=%0d done=%0d err=%0d want 5/1/0", n_b, done_n, err_n);
        end
        for (int i = 0; i < 5; i++) begin
            checks++; if (cap[i] !== expb[i]) begin errors++; $display("FAIL rstmid_byte%0d got %h want %h", i, cap[i], expb[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int dn;
        bit ended;
        send(4'hE, 0, 0, -1, 0, n_b, vcyc, done_n, err_n, plr, unstable, tmo);
        checks++; if (done !== 1'b1 || cap[0] !== 8'h1E) begin errors++; $display("FAIL b2b_stall got done=%b byte=%h want 1/1e", done, cap[0]); end
        tx_start = 1; tx_pid = 4'hA; tx_len = '0;
        @(posedge clk); #1;
        tx_start = 0;
        #1;
        checks++; if (utm_tx_valid !== 1'b1 || utm_data_out !== 8'h5A || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_nak got valid=%b data=%h busy=%b want 1/5a/1", utm_tx_valid, utm_data_out, busy);
        end
        dn = 0; ended = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #2;
            if (done) dn++;
            if (!utm_tx_valid) begin ended = 1; break; end
        end
        checks++; if (!ended || dn !== 1) begin errors++; $display("FAIL b2b_done got ended=%b done=%0d want 1/1", ended, dn); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin pay[i] = '0; cap[i] = '0; expb[i] = '0; end
        test_reset();
        test_ack();
        test_data0_zlp();
        test_data1_toggle();
        test_crc_known();
        test_underrun();
        test_reject();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
